// File: rtl/phase_tracker.sv
// Per-channel phase-input tracker: sync + rise detect, period measurement, lock/loss FSM, stretched activity LED.
// Outputs update on the 3rd clock edge after phin is first sampled high; no flow control, always accepts.
module phase_tracker #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 27,
    parameter int PER_W   = 24,
    parameter int TIMEOUT = 1_000_000,
    parameter int STRETCH = 2_500_000
) (
    input  logic                    sys_clock,
    input  logic                    sys_resetn,
    input  logic [NUM_CH-1:0]       phin,
    output logic [NUM_CH*PER_W-1:0] period_o,
    output logic [NUM_CH-1:0]       period_valid,
    output logic [NUM_CH-1:0]       locked,
    output logic [NUM_CH-1:0]       act_led,
    output logic [2:0]              rgb_led
);

    localparam int              ST_W = $clog2(STRETCH + 1);
    localparam logic [PER_W-1:0] TO_V = PER_W'(TIMEOUT);
    localparam logic [ST_W-1:0]  ST_V = ST_W'(STRETCH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [NUM_CH-1:0] s1_q, s2_q, s3_q;
    logic [NUM_CH-1:0] rise;

    assign cnt_d   = cnt_q + CNT_W'(1);
    assign rgb_led = cnt_q[CNT_W-1:CNT_W-3];
    assign rise    = s2_q & ~s3_q;

    always_ff @(posedge sys_clock) begin
        if (!sys_resetn) begin
            cnt_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            s1_q  <= phin;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q;
        logic [PER_W-1:0] pcnt_q, pcnt_d;
        logic [PER_W-1:0] per_q;
        logic [ST_W-1:0]  str_q, str_d;
        logic             vld_q;
        logic             lck_q;
        logic             timeout;

        // Counter saturates at TIMEOUT so a stalled channel holds at the loss threshold.
        always_comb begin
            pcnt_d = pcnt_q;
            str_d  = str_q;
            if (rise[i]) begin
                pcnt_d = PER_W'(1);
            end else if (pcnt_q != TO_V) begin
                pcnt_d = pcnt_q + PER_W'(1);
            end
            if (rise[i]) begin
                str_d = ST_V;
            end else if (str_q != '0) begin
                str_d = str_q - ST_W'(1);
            end
        end

        assign timeout = (pcnt_q == TO_V) && !rise[i];

        always_ff @(posedge sys_clock) begin
            if (!sys_resetn) begin
                state_q <= ST_IDLE;
                pcnt_q  <= '0;
                per_q   <= '0;
                str_q   <= '0;
                vld_q   <= 1'b0;
                lck_q   <= 1'b0;
            end else begin
                pcnt_q <= pcnt_d;
                str_q  <= str_d;
                vld_q  <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise[i]) state_q <= ST_MEASURE;
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        if (rise[i]) begin
                            state_q <= ST_LOCKED;
                            per_q   <= pcnt_q;
                            vld_q   <= 1'b1;
                            lck_q   <= 1'b1;
                        end else if (timeout) begin
                            state_q <= ST_IDLE;
                            per_q   <= '0;
                            lck_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        lck_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign period_o[i*PER_W +: PER_W] = per_q;
        assign period_valid[i]            = vld_q;
        assign locked[i]                  = lck_q;
        assign act_led[i]                 = (str_q != '0);
    end

endmodule

// File: tb/tb_phase_tracker.sv
// Bench for phase_tracker: period strobes checked by a scoreboard monitor, static outputs checked inline.
module tb_phase_tracker;

    logic        sys_clock;
    logic        sys_resetn;
    logic [1:0]  phin;
    logic [15:0] period_o;
    logic [1:0]  period_valid;
    logic [1:0]  locked;
    logic [1:0]  act_led;
    logic [2:0]  rgb_led;

    phase_tracker #(
        .NUM_CH (2),
        .CNT_W  (8),
        .PER_W  (8),
        .TIMEOUT(100),
        .STRETCH(8)
    ) dut (
        .sys_clock   (sys_clock),
        .sys_resetn  (sys_resetn),
        .phin        (phin),
        .period_o    (period_o),
        .period_valid(period_valid),
        .locked      (locked),
        .act_led     (act_led),
        .rgb_led     (rgb_led)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    int cyc = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        int per;
        int at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic pulse_train(input logic [1:0] m, input int n, input int p);
        repeat (n) begin
            phin = phin | m;
            step(2);
            phin = phin & ~m;
            step(p - 2);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation for its channel.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clock);
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                if (ch == 0 && q0.size() > 0 && cyc > q0[0].at) begin
                    e = q0.pop_front();
                    chk("missed_strobe0", 32'(cyc), 32'(e.at));
                end
                if (ch == 1 && q1.size() > 0 && cyc > q1[0].at) begin
                    e = q1.pop_front();
                    chk("missed_strobe1", 32'(cyc), 32'(e.at));
                end
                if (period_valid[ch]) begin
                    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                        chk("unexpected_strobe", 32'(ch), 32'hFFFF_FFFF);
                    end else begin
                        e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                        chk("strobe_cycle", 32'(cyc), 32'(e.at));
                        chk("strobe_period", 32'(period_o[ch*8 +: 8]), 32'(e.per));
                        chk("strobe_locked", 32'(locked[ch]), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int c0, last, d0, r, b;
        exp_t e;
        sys_resetn = 1'b0;
        phin       = 2'b00;

        // Reset with toggling inputs
        step(1); phin = 2'b01;
        step(1); phin = 2'b10;
        step(1); phin = 2'b11;
        step(1);
        chk("rst_period", 32'(period_o), 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_act", 32'(act_led), 32'd0);
        chk("rst_rgb", 32'(rgb_led), 32'd0);
        phin       = 2'b00;
        sys_resetn = 1'b1;

        // Heartbeat
        for (int k = 1; k <= 256; k++) begin
            step(1);
            if (k == 1 || k == 31 || (k % 32) == 0)
                chk("rgb", 32'(rgb_led), 32'((k % 256) / 32));
        end

        // Lock on ch0 at period 20
        c0 = cyc;
        for (int k = 1; k <= 4; k++) begin
            e.per = 20; e.at = c0 + 20 * k + 3; q0.push_back(e);
        end
        phin[0] = 1'b1; step(2); phin[0] = 1'b0; step(1);
        chk("first_rise_locked", 32'(locked[0]), 32'd0);
        chk("first_rise_act", 32'(act_led[0]), 32'd1);
        step(17);
        pulse_train(2'b01, 4, 20);
        chk("lock_locked0", 32'(locked[0]), 32'd1);
        chk("lock_period0", 32'(period_o[7:0]), 32'd20);
        chk("lock_locked1", 32'(locked[1]), 32'd0);
        chk("lock_period1", 32'(period_o[15:8]), 32'd0);

        // Loss: internal last rise at c0+83, drop 100 cycles later
        last = c0 + 83;
        step(last + 99 - cyc);
        chk("pre_loss_locked", 32'(locked[0]), 32'd1);
        chk("pre_loss_period", 32'(period_o[7:0]), 32'd20);
        step(1);
        chk("loss_locked", 32'(locked[0]), 32'd0);
        chk("loss_period", 32'(period_o[7:0]), 32'd0);

        // Re-entry then boundary rise exactly at pcnt == TIMEOUT
        d0 = cyc;
        e.per = 20;  e.at = d0 + 23;  q0.push_back(e);
        e.per = 100; e.at = d0 + 123; q0.push_back(e);
        phin[0] = 1'b1; step(2); phin[0] = 1'b0; step(1);
        chk("remeasure_locked", 32'(locked[0]), 32'd0);
        step(17);
        pulse_train(2'b01, 1, 20);
        step(80);
        pulse_train(2'b01, 1, 20);
        chk("boundary_locked", 32'(locked[0]), 32'd1);
        chk("boundary_period", 32'(period_o[7:0]), 32'd100);

        // Reset mid-period, then simultaneous re-lock on both channels
        sys_resetn = 1'b0; step(1); sys_resetn = 1'b1;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_period", 32'(period_o), 32'd0);
        chk("midrst_act", 32'(act_led), 32'd0);
        r = cyc;
        e.per = 30; e.at = r + 33;
        q0.push_back(e);
        q1.push_back(e);
        phin = 2'b11; step(2); phin = 2'b00; step(1);
        chk("relock_first_locked", 32'(locked), 32'd0);
        step(27);
        pulse_train(2'b11, 1, 30);
        chk("relock_locked", 32'(locked), 32'd3);
        chk("relock_period", 32'(period_o), 32'h1E1E);

        // Let both channels time out, then single-rise act_led on ch1
        step(120);
        chk("idle_locked", 32'(locked), 32'd0);
        chk("idle_period", 32'(period_o), 32'd0);
        phin[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            if (k == 2) phin[1] = 1'b0;
            if (k >= 2) chk("act_single", 32'(act_led[1]), 32'((k >= 3 && k <= 10) ? 1 : 0));
        end
        chk("act_other_ch", 32'(act_led[0]), 32'd0);

        // Retriggered act_led with rises 5 apart
        step(110);
        b = cyc;
        for (int k = 1; k <= 3; k++) begin
            e.per = 5; e.at = b + 5 * k + 3; q1.push_back(e);
        end
        fork
            pulse_train(2'b10, 4, 5);
            begin
                for (int k = 1; k <= 26; k++) begin
                    step(1);
                    chk("act_retrig", 32'(act_led[1]), 32'((k >= 3 && k <= 25) ? 1 : 0));
                end
            end
        join

        step(5);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
